// File: rtl/spi_slave_rx_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_rx_word_fifo
//  Brief    : First-word-fall-through word FIFO between the SPI receive side
//             and the AXI write plug. It has a synchronous flush and a sticky
//             overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave_rx_word_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow
);

  // Index width and pointer width. The pointer carries one extra wrap bit.
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_pw = c_aw + 1;

  logic [c_pw-1:0]       r_wr_ptr;
  logic [c_pw-1:0]       r_rd_ptr;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wr_en;

  // Status flags come from the pointers only. This keeps the handshakes free
  // of any combinational path.
  assign w_full  = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                   (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;
  // A flush or a reset discards a push that arrives in the same cycle.
  assign w_wr_en = w_push && !flush && !axi_areset;

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  // The pointer difference wraps modulo 2*DEPTH, so it is the fill level.
  assign count     = r_wr_ptr - r_rd_ptr;
  assign out_data  = r_mem[r_rd_ptr[c_aw-1:0]];

  // Pointer and overflow state. Priority is reset, then flush, then push/pop.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (in_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Word storage is written only on an accepted push and is never reset.
  always_ff @(posedge axi_aclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_rx_word_fifo
//  Brief    : Self-checking scoreboard bench for spi_slave_rx_word_fifo
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx_word_fifo;

  localparam int c_dw    = 32;
  localparam int c_depth = 8;

  logic              axi_aclk;
  logic              axi_areset;
  logic              flush;
  logic [c_dw-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic [c_dw-1:0]   out_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        count;
  logic              full;
  logic              empty;
  logic              overflow;

  int n_checks;
  int n_fails;

  // Reference model: queue of expected words and the sticky overflow bit
  logic [c_dw-1:0] sb[$];
  bit              m_ovf;

  spi_slave_rx_word_fifo #(.DATA_WIDTH(c_dw), .DEPTH(c_depth)) dut (
    .axi_aclk  (axi_aclk),
    .axi_areset(axi_areset),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  // Global time limit so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish, required finish before time limit");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    bit m_full;
    bit m_empty;
    m_full  = (sb.size() == c_depth);
    m_empty = (sb.size() == 0);
    chk("count",     64'(count),     64'(sb.size()));
    chk("full",      64'(full),      64'(m_full));
    chk("empty",     64'(empty),     64'(m_empty));
    chk("in_ready",  64'(in_ready),  64'(!m_full));
    chk("out_valid", 64'(out_valid), 64'(!m_empty));
    chk("overflow",  64'(overflow),  64'(m_ovf));
    if (!m_empty) chk("head_data", 64'(out_data), 64'(sb[0]));
  endtask

  // One clock cycle: capture the head, update the model at the edge, then check
  task automatic step();
    logic            cap_v;
    logic [c_dw-1:0] cap_d;
    logic [c_dw-1:0] exp_w;
    bit              m_full;
    bit              m_empty;
    cap_v   = out_valid;
    cap_d   = out_data;
    m_full  = (sb.size() == c_depth);
    m_empty = (sb.size() == 0);
    @(posedge axi_aclk);
    if (axi_areset || flush) begin
      sb.delete();
      m_ovf = 1'b0;
    end else begin
      if (in_valid && m_full) m_ovf = 1'b1;
      if (!m_empty && out_ready) begin
        exp_w = sb.pop_front();
        chk("pop_valid", 64'(cap_v), 64'd1);
        chk("pop_data",  64'(cap_d), 64'(exp_w));
      end
      if (in_valid && !m_full) sb.push_back(in_data);
    end
    #1;
    check_state();
  endtask

  task automatic drive(input logic rst, input logic fl, input logic iv,
                       input logic [c_dw-1:0] d, input logic ordy);
    axi_areset = rst;
    flush      = fl;
    in_valid   = iv;
    in_data    = d;
    out_ready  = ordy;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    m_ovf    = 1'b0;
    sb.delete();
    axi_areset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset
    drive(1, 0, 0, 32'h0, 0);
    drive(1, 0, 0, 32'h0, 0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_empty",    64'(empty),    64'd1);
    chk("rst_count",    64'(count),    64'd0);

    // Single push becomes visible in the next cycle
    drive(0, 0, 1, 32'hA5A5_0001, 0);
    chk("first_word", 64'(out_data), 64'hA5A5_0001);
    chk("first_cnt",  64'(count),    64'd1);
    drive(0, 0, 0, 32'h0, 1);

    // Fill to full, offer one extra word, then drain in order
    for (int i = 0; i < c_depth; i++) drive(0, 0, 1, 32'(i), 0);
    chk("fill_full",  64'(full),     64'd1);
    chk("fill_ready", 64'(in_ready), 64'd0);
    chk("fill_count", 64'(count),    64'd8);
    drive(0, 0, 1, 32'hDEAD_BEEF, 1);      // refused even with a pop
    chk("ovf_set", 64'(overflow), 64'd1);
    for (int i = 0; i < c_depth + 1; i++) drive(0, 0, 0, 32'h0, 1);
    chk("drain_empty", 64'(empty), 64'd1);

    // Streaming with both handshakes held high; pointers wrap several times
    for (int i = 0; i < 40; i++) drive(0, 0, 1, 32'h100 + 32'(i), 1);
    chk("stream_cnt", 64'(count), 64'd1);
    drive(0, 0, 0, 32'h0, 1);

    // Flush with five words stored, overflow set, and a push and pop pending
    for (int i = 0; i < c_depth; i++) drive(0, 0, 1, 32'h200 + 32'(i), 0);
    drive(0, 0, 1, 32'h2FF, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 32'h0, 1);
    chk("pre_flush_cnt", 64'(count),    64'd5);
    chk("pre_flush_ovf", 64'(overflow), 64'd1);
    drive(0, 1, 1, 32'h3333, 1);
    chk("flush_cnt", 64'(count),    64'd0);
    chk("flush_ovf", 64'(overflow), 64'd0);

    // Reset in the middle of traffic
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 32'h400 + 32'(i), 0);
    drive(1, 0, 1, 32'h4444, 1);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    drive(0, 0, 1, 32'h1234_5678, 0);
    chk("post_rst_head", 64'(out_data), 64'h1234_5678);
    drive(0, 0, 0, 32'h0, 1);

    // Random traffic compared against the reference queue every cycle
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 1999) == 0), ($urandom_range(0, 299) == 0),
            1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_rx_word_fifo.md
SPI_SLAVE_RX_WORD_FIFO -- requirements
Module: spi_slave_rx_word_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of one buffered word.
REQ-002 SHALL have parameter DEPTH, default 8, the number of entries; legal values are powers of two, 2..256.
REQ-003 SHALL have port axi_aclk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port axi_areset, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port flush, input, 1, synchronous clear of all stored words; pulsed at the end of an SPI transaction.
REQ-006 SHALL have port in_data, input, DATA_WIDTH, the write word from the SPI receive side (already in axi_aclk domain).
REQ-007 SHALL have port in_valid, input, 1, the write request.
REQ-008 SHALL have port in_ready, output, 1, FIFO can accept a word.
REQ-009 SHALL have port out_data, output, DATA_WIDTH, the head word; drives rx_data of the AXI write plug.
REQ-010 SHALL have port out_valid, output, 1, the head word is valid; drives rx_valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the head word; driven by rx_ready.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1, the number of stored words.
REQ-013 SHALL have port full, output, 1, count == DEPTH.
REQ-014 SHALL have port empty, output, 1, count == 0.
REQ-015 SHALL have port overflow, output, 1, sticky flag: set when a word is offered while full.

Function
REQ-016 SHALL accept a push when in_valid && in_ready; in_ready = !full, combinational from state only.
REQ-017 SHALL perform a pop when out_valid && out_ready; out_valid = !empty.
REQ-018 SHALL be first-word-fall-through: out_data always equals the oldest stored word while out_valid=1; out_data is don't-care while empty.
REQ-019 SHALL make a word pushed at edge N visible (out_valid=1, out_data=word) in the cycle after edge N; no same-cycle bypass from in_data to out_data.
REQ-020 SHALL use read/write pointers of $clog2(DEPTH)+1 bits with a wrap bit; storage index = pointer modulo DEPTH; pointers wrap from 2*DEPTH-1 to 0.
REQ-021 SHALL derive full when the pointer index bits are equal and the wrap bits differ, and empty when the pointers are equal.
REQ-022 SHALL derive count = wr_ptr - rd_ptr, modulo 2*DEPTH.
REQ-023 SHALL, on simultaneous push and pop while neither full nor empty, advance both pointers and leave count unchanged.
REQ-024 SHALL, when full, refuse a push even if a pop occurs in the same cycle (in_ready=0 while full).
REQ-025 SHALL, when empty, perform no pop (out_valid=0); a same-cycle push still completes.
REQ-026 SHALL set overflow at the edge following any cycle with in_valid=1 && full=1; overflow clears only on axi_areset or flush.
REQ-027 SHALL, on flush=1, set both pointers to 0 and clear overflow at that edge; any push or pop in the same cycle is discarded.
REQ-028 SHALL change storage contents only on an accepted push; memory needs no reset.
REQ-029 SHALL have no combinational path from in_valid/out_ready to in_ready/out_valid.

Reset
REQ-030 SHALL, while axi_areset=1 at a rising edge, clear pointers and overflow; after that edge: in_ready=1, out_valid=0, count=0, full=0, empty=1, overflow=0.
REQ-031 SHALL give axi_areset priority over flush, push and pop; reset mid-burst discards all stored words.

Verification
REQ-032 SHALL pass: reset, push 0xA5A5_0001 with out_ready=0 -> next cycle out_valid=1, out_data=0xA5A5_0001, count=1, empty=0.
REQ-033 SHALL pass: DEPTH=8, push 8 words 0..7 with out_ready=0 -> full=1, in_ready=0, count=8; 9th in_valid -> overflow=1, word dropped, then pops yield exactly 0..7 in order.
REQ-034 SHALL pass: hold in_valid=1 and out_ready=1 for 40 cycles with an incrementing source -> all 40 words out in order, count stays at 1 after the first push, pointers wrap cleanly past 15.
REQ-035 SHALL pass: with 5 words stored and overflow=1, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, empty=1, overflow=0, no word consumed or stored.
REQ-036 SHALL pass: with 3 words stored, assert axi_areset for one cycle during push/pop -> after the edge all outputs equal REQ-030 values; a subsequent push of 0x1234_5678 is the next word out.
REQ-037 SHALL pass: random valid/ready on both sides for 10k cycles against a reference queue model -> data order, count, full and empty match every cycle.
